// File: rtl/inst_fetch_buf_pkg.sv
// Shared definitions for the instruction fetch buffer: FSM state encoding,
// reset PC and the kseg0/kseg1 physical address mask.
package inst_fetch_buf_pkg;

    // IDLE: nothing pending; PEND: SRAM read issued last cycle;
    // HOLD: returned data parked while decode is stalled.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC  = 32'hbfc0_0000;
    localparam logic [31:0] KSEG_MASK = 32'h1fff_ffff;

endpackage

// File: rtl/inst_fetch_buf_addr_map.sv
// Virtual-to-physical fetch address translation. kseg0/kseg1 addresses
// (top two bits 2'b10) are unmapped by clearing the top three bits; every
// other segment passes straight through.
module fetch_addr_map
    import inst_fetch_buf_pkg::*;
(
    input  logic [31:0] pc,
    output logic [31:0] addr
);

    // Pure combinational segment decode.
    always_comb begin
        addr = pc;
        if (pc[31:30] == 2'b10) begin
            addr = pc & KSEG_MASK;
        end
    end

endmodule

// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer between the PC register, a synchronous
// instruction SRAM (data one cycle after enable) and the decode stage.
//
// Handshake: a fetch is issued in any cycle where fetch_en is high, flush
// is low, the buffer is not holding parked data and decode is not stalled
// with a read in flight. The instruction reaches decode two edges later,
// qualified by valid_d. stall_d acts as the inverse of a ready: while it is
// high the D outputs never change (except by flush or reset), and data
// returning from the SRAM is parked in a one-entry hold buffer.
//
// Optional feature: define FETCH_ADDR_CHECK_EN to add the adel_d output.
// A misaligned pc_f then suppresses the SRAM read but still travels down
// the pipe, arriving at decode with valid_d=1, inst_d=0 and adel_d=1.
module inst_fetch_buf
    import inst_fetch_buf_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] pc_f,
    input  logic        fetch_en,
    input  logic        stall_d,
    input  logic        flush,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    output logic [31:0] inst_d,
    output logic [31:0] pc_d,
    output logic        valid_d,
`ifdef FETCH_ADDR_CHECK_EN
    output logic        adel_d,
`endif
    output logic [1:0]  state_dbg
);

    fetch_state_e state;
    fetch_state_e state_nxt;

    logic        issue;
    logic        misalign;
    logic [31:0] pc_pend;
    logic [31:0] hold_buf;
    logic [31:0] hold_pc;
    logic [31:0] pend_data;

    fetch_addr_map u_addr_map (
        .pc   (pc_f),
        .addr (inst_sram_addr)
    );

`ifdef FETCH_ADDR_CHECK_EN
    logic pend_adel;
    logic hold_adel;

    assign misalign  = (pc_f[1:0] != 2'b00);
    // A misaligned fetch delivers a zero instruction instead of SRAM data.
    assign pend_data = pend_adel ? 32'h0 : inst_sram_rdata;
`else
    assign misalign  = 1'b0;
    assign pend_data = inst_sram_rdata;
`endif

    assign state_dbg = state;

    // Issue decision, SRAM enable and next-state logic.
    always_comb begin
        issue        = fetch_en & ~flush & (state != HOLD) &
                       ~((state == PEND) & stall_d);
        inst_sram_en = issue & ~misalign;
        state_nxt    = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = issue ? PEND : IDLE;
                PEND:    state_nxt = stall_d ? HOLD : (issue ? PEND : IDLE);
                HOLD:    state_nxt = stall_d ? HOLD : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pending PC, hold buffer and decode-stage outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_pend  <= 32'h0;
            hold_buf <= 32'h0;
            hold_pc  <= 32'h0;
            inst_d   <= 32'h0;
            pc_d     <= RESET_PC;
            valid_d  <= 1'b0;
        end else if (flush) begin
            // Redirect: nothing in flight or parked may reach decode.
            hold_buf <= 32'h0;
            hold_pc  <= 32'h0;
            valid_d  <= 1'b0;
        end else begin
            if (issue) begin
                pc_pend <= pc_f;
            end
            case (state)
                PEND: begin
                    if (stall_d) begin
                        hold_buf <= pend_data;
                        hold_pc  <= pc_pend;
                    end else begin
                        inst_d  <= pend_data;
                        pc_d    <= pc_pend;
                        valid_d <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall_d) begin
                        inst_d  <= hold_buf;
                        pc_d    <= hold_pc;
                        valid_d <= 1'b1;
                    end
                end
                default: begin
                    if (!stall_d) begin
                        valid_d <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef FETCH_ADDR_CHECK_EN
    // Address-error flag follows its fetch through pend, hold and decode.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_adel <= 1'b0;
            hold_adel <= 1'b0;
            adel_d    <= 1'b0;
        end else if (flush) begin
            hold_adel <= 1'b0;
            adel_d    <= 1'b0;
        end else begin
            if (issue) begin
                pend_adel <= misalign;
            end
            case (state)
                PEND: begin
                    if (stall_d) begin
                        hold_adel <= pend_adel;
                    end else begin
                        adel_d <= pend_adel;
                    end
                end
                HOLD: begin
                    if (!stall_d) begin
                        adel_d <= hold_adel;
                    end
                end
                default: begin
                    if (!stall_d) begin
                        adel_d <= 1'b0;
                    end
                end
            endcase
        end
    end
`endif

endmodule

// File: doc/inst_fetch_buf.md
INST_FETCH_BUF -- requirements
Module: inst_fetch_buf

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port pc_f, input, 32 bits: fetch-stage virtual PC from the PC register.
REQ-004 SHALL have port fetch_en, input, 1 bit: fetch stage requests an instruction at pc_f this cycle.
REQ-005 SHALL have port stall_d, input, 1 bit: decode stage cannot accept a new instruction.
REQ-006 SHALL have port flush, input, 1 bit: exception/eret redirect; discard all in-flight fetches.
REQ-007 SHALL have port inst_sram_en, output, 1 bit: SRAM read enable.
REQ-008 SHALL have port inst_sram_addr, output, 32 bits: SRAM physical byte address.
REQ-009 SHALL have port inst_sram_rdata, input, 32 bits: SRAM read data, valid one cycle after the enable.
REQ-010 SHALL have ports inst_d (32), pc_d (32), valid_d (1), all outputs: decode-stage instruction, its PC, and a qualifier.

Function
REQ-011 SHALL have three states: IDLE (nothing pending), PEND (read issued last cycle), HOLD (data captured while decode is stalled).
REQ-012 SHALL drive inst_sram_en = fetch_en & ~flush & (state != HOLD) & ~(state == PEND & stall_d), combinationally.
REQ-013 SHALL map inst_sram_addr as follows: kseg0/kseg1 (pc_f[31:30]==2'b10) gives {3'b000, pc_f[28:0]}; otherwise pc_f passes through unchanged.
REQ-014 SHALL latch pc_f into pc_pend whenever inst_sram_en=1, and move to PEND.
REQ-015 In PEND with stall_d=0: inst_d<=inst_sram_rdata, pc_d<=pc_pend, valid_d<=1; next state is PEND if a new read issued, else IDLE.
REQ-016 In PEND with stall_d=1: hold_buf<=inst_sram_rdata, hold_pc<=pc_pend; move to HOLD; D outputs unchanged.
REQ-017 In HOLD with stall_d=0: inst_d<=hold_buf, pc_d<=hold_pc, valid_d<=1; move to IDLE. No new read is issued in that cycle.
REQ-018 In IDLE with stall_d=0 and no pending data: valid_d<=0. With stall_d=1, the D outputs SHALL hold.
REQ-019 Load-to-use latency SHALL be exactly 2 edges from inst_sram_en to valid_d when there is no stall.
REQ-020 flush SHALL take priority over all else: valid_d<=0, state<=IDLE, hold contents discarded. Any rdata returning in the next cycle SHALL be ignored.
REQ-021 When stall_d and flush are asserted together, flush SHALL win.

Reset
REQ-022 On resetn=0, asynchronously: state=IDLE, valid_d=0, inst_d=0, pc_d=32'hbfc0_0000, hold_buf=0, pc_pend=0.
REQ-023 Reset asserted mid-PEND or mid-HOLD SHALL drop the pending data. The first enable after release SHALL come from fetch_en only.

Configuration
REQ-024 Macro FETCH_ADDR_CHECK_EN:
- Defined: add output adel_d. When pc_f[1:0]!=0, suppress inst_sram_en, and deliver adel_d=1 with valid_d=1 and inst_d=0 on the same timing as a normal fetch.
- Undefined: no adel_d port; pc_f[1:0] is ignored.

Structure
REQ-025 The shared package SHALL hold the state encoding (IDLE=2'd0, PEND=2'd1, HOLD=2'd2), the reset PC constant 32'hbfc0_0000, and the kseg mask 32'h1fff_ffff.
REQ-026 Sub-module fetch_addr_map SHALL implement the REQ-013 mapping combinationally. Everything else stays in one module.

Verification
REQ-027 Back-to-back fetch of pc 0xbfc00000, 0xbfc00004, no stall -> en with addr 0x1fc00000, then 0x1fc00004; valid_d=1 two edges later with matching pc_d.
REQ-028 stall_d=1 for 3 cycles while PEND with rdata 0x24080001 -> state HOLD, inst_sram_en=0. After release, inst_d=0x24080001 for exactly one accepted cycle.
REQ-029 flush in the PEND cycle with rdata 0xdeadbeef -> valid_d=0 next edge; 0xdeadbeef never appears on inst_d.
REQ-030 flush and stall_d together in HOLD -> IDLE, valid_d=0, hold discarded.
REQ-031 resetn pulsed low mid-HOLD -> immediate pc_d=0xbfc00000, valid_d=0. With FETCH_ADDR_CHECK_EN, pc_f=0xbfc00002 -> inst_sram_en=0, adel_d=1 two edges later.
